// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU memory-bus responder.
// Region decode encoding and I/O window offsets.
package mem_io_responder_pkg;

    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [2:0]  IO_OFS_UART = 3'd0;
    localparam logic [2:0]  IO_OFS_CLK  = 3'd4;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_UART,
        SEL_CLK,
        SEL_NONE
    } sel_e;

    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_BASE[17:16];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with occupancy count.
// Pop on empty is ignored; push on full is dropped unless a pop frees a slot.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push,
    input  logic [7:0]            wdata,
    input  logic                  pop,
    output logic [7:0]            rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array write port.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: block RAM plus the I/O window.
// UART FIFOs, free-running cycle counter, program-stop flag, rdy control.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 2,
    parameter int RAM_ADDR_W    = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           cpu_addr,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_dout,
    output logic [7:0]            cpu_din,
    output logic                  cpu_rdy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic                  uart_tx_valid,
    output logic [7:0]            uart_tx_data,
    input  logic                  uart_tx_ready,
    input  logic                  uart_rx_valid,
    input  logic [7:0]            uart_rx_data,
    output logic                  uart_rx_ready,
    output logic                  program_stop
);

    localparam logic [TX_DEPTH_LOG2:0] TX_RDY_LIM =
        (TX_DEPTH_LOG2 + 1)'((1 << TX_DEPTH_LOG2) - 1);

    sel_e                 sel;
    sel_e                 rd_sel;
    logic                 accepted;
    logic                 rd_req;
    logic                 wr_req;
    logic                 clk_latch;
    logic                 stop_set;
    logic                 rd_pending;
    logic [7:0]           io_next;
    logic [7:0]           io_byte;
    logic [7:0]           din_hold;
    logic [31:0]          counter;
    logic [31:0]          snapshot;
    logic                 tx_push;
    logic [7:0]           tx_wdata;
    logic                 tx_full;
    logic                 tx_empty;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic                 rx_push;
    logic                 rx_pop;
    logic [7:0]           rx_rdata;
    logic                 rx_full;
    logic                 rx_empty;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic                 unused_ok;

    // A frozen CPU holds its outputs, so only rdy cycles carry requests.
    assign cpu_rdy   = (tx_count < TX_RDY_LIM);
    assign accepted  = cpu_rdy & ~rst_in;
    assign rd_req    = accepted & ~cpu_wr;
    assign wr_req    = accepted & cpu_wr;

    assign ram_en    = accepted & (sel == SEL_RAM);
    assign ram_we    = ram_en & cpu_wr;
    assign ram_addr  = cpu_addr[RAM_ADDR_W-1:0];
    assign ram_wdata = cpu_dout;

    assign clk_latch = rd_req & (sel == SEL_CLK) & (cpu_addr[1:0] == 2'b00);
    assign stop_set  = wr_req & (sel == SEL_CLK) & (cpu_addr[1:0] == 2'b00);
    assign tx_push   = (wr_req & (sel == SEL_UART) & (cpu_dout != 8'h00))
                     | stop_set;
    assign tx_wdata  = stop_set ? 8'h00 : cpu_dout;
    assign rx_pop    = rd_req & (sel == SEL_UART);
    assign rx_push   = uart_rx_valid & ~rx_full;

    assign uart_tx_valid = ~tx_empty;
    assign uart_rx_ready = ~rx_full;
    assign unused_ok     = ^{cpu_addr[31:18], rx_count};

    // Region decode of the current bus address.
    always_comb begin
        sel = SEL_NONE;
        unique case (1'b1)
            !is_io(cpu_addr):
                sel = SEL_RAM;
            is_io(cpu_addr) && (cpu_addr[2:0] == IO_OFS_UART):
                sel = SEL_UART;
            is_io(cpu_addr) && (cpu_addr[2] == IO_OFS_CLK[2]):
                sel = SEL_CLK;
            default:
                sel = SEL_NONE;
        endcase
    end

    // I/O read byte; offset 4 returns the value being latched this edge.
    always_comb begin
        io_next = 8'h00;
        if (sel == SEL_UART) begin
            io_next = rx_empty ? 8'h00 : rx_rdata;
        end else if (sel == SEL_CLK) begin
            unique case (cpu_addr[1:0])
                2'd0: io_next = counter[7:0];
                2'd1: io_next = snapshot[15:8];
                2'd2: io_next = snapshot[23:16];
                2'd3: io_next = snapshot[31:24];
            endcase
        end
    end

    // Returned byte is selected one cycle after the request, else held.
    always_comb begin
        cpu_din = din_hold;
        if (rd_pending) begin
            cpu_din = (rd_sel == SEL_RAM) ? ram_rdata : io_byte;
        end
    end

    // Read pipeline, counter, snapshot and stop flag state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_pending   <= 1'b0;
            rd_sel       <= SEL_RAM;
            io_byte      <= 8'h00;
            din_hold     <= 8'h00;
            counter      <= 32'h0;
            snapshot     <= 32'h0;
            program_stop <= 1'b0;
        end else begin
            rd_pending <= rd_req;
            din_hold   <= cpu_din;
            counter    <= counter + 32'd1;
            if (rd_req) begin
                rd_sel  <= sel;
                io_byte <= io_next;
            end
            if (clk_latch) begin
                snapshot <= counter;
            end
            if (stop_set) begin
                program_stop <= 1'b1;
            end
        end
    end

    byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (tx_push),
        .wdata  (tx_wdata),
        .pop    (uart_tx_ready),
        .rdata  (uart_tx_data),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (rx_push),
        .wdata  (uart_rx_data),
        .pop    (rx_pop),
        .rdata  (rx_rdata),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder.
// Drives on negedge, samples on the following negedge.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        ram_en;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready;
    logic        program_stop;

    int          checks = 0;
    int          failures = 0;
    int          ovf = 0;
    logic [31:0] edges;
    logic [7:0]  ram [1024];
    logic [7:0]  tx_log [$];

    mem_io_responder dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .cpu_addr      (cpu_addr),
        .cpu_wr        (cpu_wr),
        .cpu_dout      (cpu_dout),
        .cpu_din       (cpu_din),
        .cpu_rdy       (cpu_rdy),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready),
        .program_stop  (program_stop)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous block-RAM model, read-first.
    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr[9:0]] <= ram_wdata;
            ram_rdata <= ram[ram_addr[9:0]];
        end
    end

    // Record every byte the UART consumes.
    always @(posedge clk_in) begin
        if (!rst_in && uart_tx_valid && uart_tx_ready)
            tx_log.push_back(uart_tx_data);
    end

    // Reference cycle count since reset release.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) edges <= 32'h0;
        else        edges <= edges + 32'd1;
    end

    // A push into a full TX FIFO must never be attempted.
    always @(posedge clk_in) begin
        if (dut.tx_push && dut.tx_full) ovf <= ovf + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cpu_addr = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_wr   = 1'b1;
        cpu_dout = d;
        @(negedge clk_in);
        idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e,
                      input string tag);
        cpu_addr = a;
        cpu_wr   = 1'b0;
        @(negedge clk_in);
        chk(tag, {24'h0, cpu_din}, {24'h0, e});
        idle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        idle();
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
        repeat (2) @(negedge clk_in);

        chk("rst_din", cpu_din, 0);
        chk("rst_rdy", cpu_rdy, 1);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_tx_valid", uart_tx_valid, 0);
        chk("rst_rx_ready", uart_rx_ready, 1);
        chk("rst_stop", program_stop, 0);
        rst_in = 1'b0;

        // RAM write then read with one-cycle latency.
        cpu_addr = 32'h100; cpu_wr = 1'b1; cpu_dout = 8'hA5;
        #1;
        chk("ram_we_wr", ram_we, 1);
        chk("ram_en_wr", ram_en, 1);
        chk("ram_addr", ram_addr, 17'h100);
        chk("ram_wdata", ram_wdata, 8'hA5);
        @(negedge clk_in);
        cpu_addr = 32'h100; cpu_wr = 1'b0;
        #1;
        chk("ram_we_rd", ram_we, 0);
        chk("ram_lat0", cpu_din, 0);
        @(negedge clk_in);
        chk("ram_lat1", cpu_din, 8'hA5);
        idle();

        // UART TX, zero byte suppressed.
        uart_tx_ready = 1'b1;
        wr(32'h30000, 8'h48);
        wr(32'h30000, 8'h69);
        wr(32'h30000, 8'h00);
        repeat (4) @(negedge clk_in);
        chk("tx_cnt", tx_log.size(), 2);
        chk("tx_b0", tx_log[0], 8'h48);
        chk("tx_b1", tx_log[1], 8'h69);
        chk("tx_idle", uart_tx_valid, 0);

        // UART RX, including reads while empty.
        uart_rx_valid = 1'b1; uart_rx_data = 8'h31;
        @(negedge clk_in);
        uart_rx_data = 8'h32;
        @(negedge clk_in);
        uart_rx_valid = 1'b0;
        rd(32'h30000, 8'h31, "rx_b0");
        rd(32'h30000, 8'h32, "rx_b1");
        rd(32'h30000, 8'h00, "rx_empty0");
        rd(32'h30000, 8'h00, "rx_empty1");
        chk("rx_ready", uart_rx_ready, 1);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
        @(negedge clk_in);
        uart_rx_valid = 1'b0;
        rd(32'h30000, 8'h33, "rx_after_empty");
        rd(32'h30002, 8'h00, "io_other");

        // Coherent counter snapshot across a byte carry.
        begin
            int g = 0;
            while (edges != 32'h1FF && g < 2000) begin
                @(negedge clk_in);
                g++;
            end
            chk("cnt_sync_timeout", edges, 32'h1FF);
        end
        rd(32'h30004, 8'hFF, "clk_b0");
        rd(32'h30005, 8'h01, "clk_b1");
        rd(32'h30006, 8'h00, "clk_b2");
        rd(32'h30007, 8'h00, "clk_b3");
        rd(32'h30004, 8'h03, "clk_relatch");

        // TX backpressure: rdy drops at 15 entries, held write not repeated.
        uart_tx_ready = 1'b0;
        tx_log.delete();
        for (int i = 0; i < 16; i++) begin
            cpu_addr = 32'h30000; cpu_wr = 1'b1; cpu_dout = 8'(i + 1);
            #1;
            chk($sformatf("rdy_w%0d", i), cpu_rdy, (i < 15) ? 1 : 0);
            @(negedge clk_in);
        end
        repeat (3) @(negedge clk_in);
        chk("rdy_held", cpu_rdy, 0);
        chk("tx_valid_full", uart_tx_valid, 1);
        uart_tx_ready = 1'b1;
        @(negedge clk_in);
        uart_tx_ready = 1'b0;
        chk("rdy_back", cpu_rdy, 1);
        @(negedge clk_in);
        idle();
        chk("rdy_refull", cpu_rdy, 0);
        uart_tx_ready = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("tx_full_cnt", tx_log.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("tx_full_b%0d", i), tx_log[i], 32'(i + 1));
        chk("tx_overflow", ovf, 0);

        // Program stop on offset 4 only.
        tx_log.delete();
        wr(32'h30005, 8'h77);
        repeat (3) @(negedge clk_in);
        chk("stop_ofs5", program_stop, 0);
        chk("tx_ofs5", tx_log.size(), 0);
        wr(32'h30004, 8'h55);
        repeat (3) @(negedge clk_in);
        chk("stop_set", program_stop, 1);
        chk("tx_stop_cnt", tx_log.size(), 1);
        chk("tx_stop_b", tx_log[0], 8'h00);

        // Reset in the middle of a RAM read.
        uart_tx_ready = 1'b0;
        wr(32'h30000, 8'h5A);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h44;
        @(negedge clk_in);
        uart_rx_valid = 1'b0;
        cpu_addr = 32'h100; cpu_wr = 1'b0;
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("rst_mid_din", cpu_din, 0);
        chk("rst_mid_stop", program_stop, 0);
        chk("rst_mid_txv", uart_tx_valid, 0);
        chk("rst_mid_rdy", cpu_rdy, 1);
        @(negedge clk_in);
        idle();
        rst_in = 1'b0;
        rd(32'h30004, 8'h00, "cnt_rst0");
        rd(32'h30004, 8'h01, "cnt_rst1");
        rd(32'h30000, 8'h00, "rx_rst_empty");
        chk("tx_rst_empty", uart_tx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
